bicubic_out_reorder: RTL and testbench
======================================

Name: bicubic_out_reorder

Overview:
- Downstream neighbour of the 4x bicubic upsample core.
- Per input pixel window, the core emits 4 beats of 4 output pixels (beat k = output row k, lanes = 4 adjacent output columns).
- This block collects one full strip (IN_W windows x 4 beats), then re-serialises it as a raster pixel stream: 4 output rows of 4*IN_W pixels, one pixel per cycle, with line/frame markers for the output writer.

Parameters:
- CHANNEL_WIDTH, 8, bits per pixel channel.
- IN_W, 960, input pixels per line (windows per strip); output line = 4*IN_W.
- IN_H, 540, input lines per frame (strips per frame).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- bcci_rsp_valid  input  1  upsample core has a 4-pixel beat.
- bf_rsp_ready  output  1  block accepts the beat.
- bcci_rsp_data1..bcci_rsp_data4  input  CHANNEL_WIDTH each  output columns 4w+0..4w+3 of the current beat's row.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts pixel.
- out_data  output  CHANNEL_WIDTH  raster pixel.
- out_sof  output  1  first pixel of frame, qualified by out_valid.
- out_eol  output  1  last pixel of an output line, qualified by out_valid.
- out_eof  output  1  last pixel of frame, qualified by out_valid.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- On reset: state FILL; all counters 0; bf_rsp_ready=0 during rst, then 1 from the first clk after release; out_valid=0, out_data=0, out_sof/out_eol/out_eof=0. Buffer contents are not reset.
- Storage: 4 rows x IN_W words of 4*CHANNEL_WIDTH bits, synchronous-read RAM (1-cycle read latency).
- Input handshake: bcci_rsp_valid & bf_rsp_ready. Data is stored unmodified into row=beat_cnt, word=win_cnt.
- Counters: beat_cnt 0..3 steps per input handshake and wraps. win_cnt steps when beat_cnt wraps.
- FILL state:
  - bf_rsp_ready=1.
  - On the handshake with beat_cnt=3 and win_cnt=IN_W-1, go to DRAIN next cycle.
  - bf_rsp_ready drops in that same next cycle; no beat is accepted in DRAIN.
- DRAIN state:
  - Counters: out_col 0..4*IN_W-1, then out_row 0..3.
  - Read address: word = out_col>>2, lane = out_col[1:0]. Lane 0 maps to data1.
  - Output register: holds one pixel. Refill it whenever it is empty or being consumed (out_valid & out_ready), via RAM read plus a 1-cycle pipeline.
  - Sustained throughput is 1 pixel/cycle with out_ready high. First out_valid is 2 cycles after entering DRAIN.
  - out_valid stays asserted until handshaken; out_data and markers stay stable while stalled.
- Markers:
  - out_eol=1 when out_col=4*IN_W-1.
  - out_sof=1 for strip_cnt=0, row 0, col 0.
  - out_eof=1 for strip_cnt=IN_H-1, row 3, last col.
- End of strip: on the handshake of the row-3 last-column pixel, go to FILL; bf_rsp_ready=1 the next cycle. strip_cnt increments and wraps to 0 after IN_H-1.
- Simultaneous events: in the last DRAIN cycle, the final output handshake and FILL re-entry do not overlap input acceptance. The FILL->DRAIN edge is a single cycle with no input accepted.
- Backpressure: out_ready low for any duration loses or duplicates no pixel. bcci_rsp_valid held high during DRAIN causes no acceptance.
- Reset mid-operation (FILL or DRAIN): immediate return to reset values; the partial strip is discarded; the next accepted beat is treated as row 0 of window 0 of strip 0.

Test Plan:
- Pixel encoding: IN_W=2, IN_H=2; beat k of window w drives lane j = 16k+4w+j.
- Basic strip: stream 8 beats with out_ready=1 -> 32 pixels; row r col c = 16r+c (0..7, 16..23, 32..39, 48..55); out_eol on c=7; out_sof only on the first pixel; bf_rsp_ready=0 throughout the drain.
- Frame end: run 2 strips -> out_eof only on the 64th pixel (value 55 of strip 1); strip_cnt wraps; a third strip gives out_sof again.
- Output backpressure: toggle out_ready with a 1-in-3 pattern -> identical 32-value sequence; out_data stable while out_valid & !out_ready.
- Input gaps: bcci_rsp_valid random 50% -> same output; DRAIN entered exactly 1 cycle after the 8th beat handshake.
- Reset mid-drain: assert rst after 10 pixels out -> out_valid=0 and bf_rsp_ready=0 during rst; after release a fresh strip drains from value 0 with out_sof=1.

Source files
------------

// File: rtl/bicubic_out_reorder.sv
// Collects one strip of 4-pixel beats from the bicubic upsample core into a
// 4-row buffer, then replays it as a raster pixel stream with SOF/EOL/EOF markers.
module bicubic_out_reorder #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int IN_W          = 960,
  parameter int IN_H          = 540
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bcci_rsp_valid,
  output logic                     bf_rsp_ready,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNEL_WIDTH-1:0] out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof
);

  localparam int WW   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int COLW = WW + 2;
  localparam int SW   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int BW   = 4 * CHANNEL_WIDTH;

  localparam logic [WW-1:0]   LAST_WIN   = WW'(IN_W - 1);
  localparam logic [COLW-1:0] LAST_COL   = COLW'(4 * IN_W - 1);
  localparam logic [SW-1:0]   LAST_STRIP = SW'(IN_H - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic [1:0]              beatCnt_q;
  logic [WW-1:0]           winCnt_q;
  logic [SW-1:0]           stripCnt_q;

  logic [COLW-1:0]         rdCol_q;
  logic [1:0]              rdRow_q;
  logic                    rdPend_q;

  logic                    s1Valid_q;
  logic [1:0]              s1Lane_q;
  logic                    s1Sof_q;
  logic                    s1Eol_q;
  logic                    s1Eof_q;
  logic                    s1Last_q;

  logic                    outValid_q;
  logic [CHANNEL_WIDTH-1:0] outData_q;
  logic                    outSof_q;
  logic                    outEol_q;
  logic                    outEof_q;
  logic                    outLast_q;

  logic [BW-1:0]           mem_q [4][IN_W];
  logic [BW-1:0]           ram_q;

  logic                    inHs_d;
  logic                    outHs_d;
  logic                    advance_d;
  logic                    issue_d;
  logic                    rdColLast_d;

  // Stage 1 (RAM output) may only be refilled when it is empty or about to
  // move into the output register, so a stalled consumer freezes the pipe.
  always_comb begin
    inHs_d      = bcci_rsp_valid & ready_q;
    outHs_d     = outValid_q & out_ready;
    advance_d   = ~outValid_q | out_ready;
    issue_d     = (state_q == DRAIN) & rdPend_q & (~s1Valid_q | advance_d);
    rdColLast_d = (rdCol_q == LAST_COL);
  end

  always_ff @(posedge clk) begin
    if (inHs_d) begin
      mem_q[beatCnt_q][winCnt_q] <= {bcci_rsp_data4, bcci_rsp_data3,
                                     bcci_rsp_data2, bcci_rsp_data1};
    end
    if (issue_d) begin
      ram_q <= mem_q[rdRow_q][rdCol_q[COLW-1:2]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      ready_q    <= 1'b0;
      beatCnt_q  <= '0;
      winCnt_q   <= '0;
      stripCnt_q <= '0;
      rdCol_q    <= '0;
      rdRow_q    <= '0;
      rdPend_q   <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1Lane_q   <= '0;
      s1Sof_q    <= 1'b0;
      s1Eol_q    <= 1'b0;
      s1Eof_q    <= 1'b0;
      s1Last_q   <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSof_q   <= 1'b0;
      outEol_q   <= 1'b0;
      outEof_q   <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          ready_q <= 1'b1;
          if (inHs_d) begin
            beatCnt_q <= beatCnt_q + 2'd1;
            if (beatCnt_q == 2'd3) begin
              if (winCnt_q == LAST_WIN) begin
                winCnt_q <= '0;
                state_q  <= DRAIN;
                ready_q  <= 1'b0;
                rdPend_q <= 1'b1;
                rdCol_q  <= '0;
                rdRow_q  <= '0;
              end else begin
                winCnt_q <= winCnt_q + WW'(1);
              end
            end
          end
        end
        DRAIN: begin
          ready_q <= 1'b0;
          if (outHs_d && outLast_q) begin
            state_q    <= FILL;
            ready_q    <= 1'b1;
            stripCnt_q <= (stripCnt_q == LAST_STRIP) ? '0 : stripCnt_q + SW'(1);
          end
        end
        default: state_q <= FILL;
      endcase

      // Read-address walk: columns of a row, then the next row, until row 3 ends.
      if (issue_d) begin
        s1Lane_q <= rdCol_q[1:0];
        s1Eol_q  <= rdColLast_d;
        s1Sof_q  <= (stripCnt_q == '0) && (rdRow_q == 2'd0) && (rdCol_q == '0);
        s1Eof_q  <= (stripCnt_q == LAST_STRIP) && (rdRow_q == 2'd3) && rdColLast_d;
        s1Last_q <= (rdRow_q == 2'd3) && rdColLast_d;
        if (rdColLast_d) begin
          rdCol_q <= '0;
          if (rdRow_q == 2'd3) begin
            rdPend_q <= 1'b0;
          end else begin
            rdRow_q <= rdRow_q + 2'd1;
          end
        end else begin
          rdCol_q <= rdCol_q + COLW'(1);
        end
      end

      if (issue_d) begin
        s1Valid_q <= 1'b1;
      end else if (advance_d) begin
        s1Valid_q <= 1'b0;
      end

      if (advance_d) begin
        outValid_q <= s1Valid_q;
        if (s1Valid_q) begin
          outData_q <= ram_q[s1Lane_q*CHANNEL_WIDTH +: CHANNEL_WIDTH];
          outSof_q  <= s1Sof_q;
          outEol_q  <= s1Eol_q;
          outEof_q  <= s1Eof_q;
          outLast_q <= s1Last_q;
        end else begin
          outSof_q  <= 1'b0;
          outEol_q  <= 1'b0;
          outEof_q  <= 1'b0;
          outLast_q <= 1'b0;
        end
      end
    end
  end

  assign bf_rsp_ready = ready_q;
  assign out_valid    = outValid_q;
  assign out_data     = outData_q;
  assign out_sof      = outSof_q;
  assign out_eol      = outEol_q;
  assign out_eof      = outEof_q;

endmodule

// File: tb/tb_bicubic_out_reorder.sv
// Bench for bicubic_out_reorder at IN_W=2, IN_H=2: table of strip scenarios plus
// a mid-drain reset sequence, each pixel checked against a raster model.
module tb_bicubic_out_reorder;

  localparam int CW   = 8;
  localparam int IN_W = 2;
  localparam int IN_H = 2;
  localparam int NPIX = 16 * IN_W;
  localparam int NBEAT = 4 * IN_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bcci_rsp_valid = 1'b0;
  logic          bf_rsp_ready;
  logic [CW-1:0] bcci_rsp_data1 = '0;
  logic [CW-1:0] bcci_rsp_data2 = '0;
  logic [CW-1:0] bcci_rsp_data3 = '0;
  logic [CW-1:0] bcci_rsp_data4 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;

  int tests = 0;
  int fails = 0;
  int modelStrip = 0;
  int pixTotal = 0;
  int sofCnt = 0;
  int eolCnt = 0;
  int eofCnt = 0;

  typedef struct {
    int strips;
    bit randData;
    int validPct;
    int readyMode;
    int expPixels;
    int expSof;
    int expEol;
    int expEof;
  } vec_t;

  vec_t vecs[5];

  bicubic_out_reorder #(
    .CHANNEL_WIDTH(CW),
    .IN_W(IN_W),
    .IN_H(IN_H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bcci_rsp_valid(bcci_rsp_valid),
    .bf_rsp_ready(bf_rsp_ready),
    .bcci_rsp_data1(bcci_rsp_data1),
    .bcci_rsp_data2(bcci_rsp_data2),
    .bcci_rsp_data3(bcci_rsp_data3),
    .bcci_rsp_data4(bcci_rsp_data4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int packPix(input int data, input int sof, input int eol, input int eof);
    return data * 8 + sof * 4 + eol * 2 + eof;
  endfunction

  task automatic doReset();
    rst = 1'b1;
    bcci_rsp_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("resetReady", int'(bf_rsp_ready), 0);
    checkOutput("resetValid", int'(out_valid), 0);
    checkOutput("resetData", int'(out_data), 0);
    checkOutput("resetMarkers", int'({out_sof, out_eol, out_eof}), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", int'(bf_rsp_ready), 1);
    modelStrip = 0;
  endtask

  // Streams one strip of beats and consumes up to stopAfter raster pixels.
  // Inputs change on the falling edge; handshakes are judged on the values
  // that will be present at the following rising edge.
  task automatic applyStimulus(input bit randData, input int validPct,
                               input int readyMode, input int stopAfter);
    int beats[4][IN_W][4];
    int expPix[NPIX];
    int beatIdx = 0;
    int pixIdx = 0;
    int cyc = 0;
    int lastHsCyc = -1;
    int firstValid = -1;
    int readyErr = 0;
    bit holdValid = 0;
    int holdVal = 0;
    int cur;
    int w;
    int k;

    for (int kk = 0; kk < 4; kk++)
      for (int ww = 0; ww < IN_W; ww++)
        for (int j = 0; j < 4; j++)
          beats[kk][ww][j] = randData ? int'($urandom_range(0, 255)) : 16 * kk + 4 * ww + j;

    for (int p = 0; p < NPIX; p++) begin
      int r = p / (4 * IN_W);
      int c = p % (4 * IN_W);
      expPix[p] = packPix(beats[r][c / 4][c % 4],
                          (modelStrip == 0 && p == 0) ? 1 : 0,
                          (c == 4 * IN_W - 1) ? 1 : 0,
                          (modelStrip == IN_H - 1 && p == NPIX - 1) ? 1 : 0);
    end

    while (pixIdx < stopAfter && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      cur = packPix(int'(out_data), int'(out_sof), int'(out_eol), int'(out_eof));

      if (holdValid) begin
        checkOutput("stallValid", int'(out_valid), 1);
        checkOutput("stallStable", cur, holdVal);
      end
      if (lastHsCyc >= 0 && bf_rsp_ready) readyErr = 1;
      if (out_valid && firstValid < 0) firstValid = cyc;

      if (beatIdx < NBEAT) begin
        w = beatIdx / 4;
        k = beatIdx % 4;
        bcci_rsp_valid = ($urandom_range(0, 99) < validPct);
        bcci_rsp_data1 = CW'(beats[k][w][0]);
        bcci_rsp_data2 = CW'(beats[k][w][1]);
        bcci_rsp_data3 = CW'(beats[k][w][2]);
        bcci_rsp_data4 = CW'(beats[k][w][3]);
      end else begin
        bcci_rsp_valid = 1'b1;
        bcci_rsp_data1 = 8'hEE;
        bcci_rsp_data2 = 8'hEE;
        bcci_rsp_data3 = 8'hEE;
        bcci_rsp_data4 = 8'hEE;
      end
      case (readyMode)
        1:       out_ready = (cyc % 3 != 0);
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase

      if (bcci_rsp_valid && bf_rsp_ready) begin
        beatIdx++;
        if (beatIdx == NBEAT) lastHsCyc = cyc;
      end
      if (out_valid && out_ready) begin
        checkOutput("pixel", cur, expPix[pixIdx % NPIX]);
        pixIdx++;
        pixTotal++;
        sofCnt += int'(out_sof);
        eolCnt += int'(out_eol);
        eofCnt += int'(out_eof);
      end
      holdValid = out_valid && !out_ready;
      holdVal = cur;
    end

    if (cyc >= 2000) checkOutput("timeout", pixIdx, stopAfter);
    checkOutput("drainLatency", firstValid - lastHsCyc, 3);
    checkOutput("readyLowInDrain", readyErr, 0);

    if (stopAfter == NPIX) begin
      @(negedge clk);
      bcci_rsp_valid = 1'b0;
      out_ready = 1'b0;
      checkOutput("readyAfterDrain", int'(bf_rsp_ready), 1);
      checkOutput("validAfterDrain", int'(out_valid), 0);
      modelStrip = (modelStrip + 1) % IN_H;
    end
  endtask

  initial begin
    // strips, randData, validPct, readyMode, pixels, sof, eol, eof
    vecs[0] = '{1, 1'b0, 100, 0, 32, 1, 4, 0};
    vecs[1] = '{3, 1'b0, 100, 0, 96, 2, 12, 1};
    vecs[2] = '{1, 1'b0, 100, 1, 32, 1, 4, 0};
    vecs[3] = '{2, 1'b1, 50, 0, 64, 1, 8, 1};
    vecs[4] = '{2, 1'b1, 50, 2, 64, 1, 8, 1};

    for (int i = 0; i < 5; i++) begin
      doReset();
      pixTotal = 0;
      sofCnt = 0;
      eolCnt = 0;
      eofCnt = 0;
      for (int s = 0; s < vecs[i].strips; s++)
        applyStimulus(vecs[i].randData, vecs[i].validPct, vecs[i].readyMode, NPIX);
      checkOutput($sformatf("vec%0d pixels", i), pixTotal, vecs[i].expPixels);
      checkOutput($sformatf("vec%0d sofCount", i), sofCnt, vecs[i].expSof);
      checkOutput($sformatf("vec%0d eolCount", i), eolCnt, vecs[i].expEol);
      checkOutput($sformatf("vec%0d eofCount", i), eofCnt, vecs[i].expEof);
    end

    // Reset in the middle of a drain discards the strip and restarts the frame.
    doReset();
    applyStimulus(1'b0, 100, 0, 10);
    rst = 1'b1;
    #1;
    checkOutput("midResetValid", int'(out_valid), 0);
    checkOutput("midResetReady", int'(bf_rsp_ready), 0);
    @(negedge clk);
    checkOutput("midResetHoldReady", int'(bf_rsp_ready), 0);
    rst = 1'b0;
    bcci_rsp_valid = 1'b0;
    modelStrip = 0;
    @(negedge clk);
    checkOutput("midResetReadyBack", int'(bf_rsp_ready), 1);
    sofCnt = 0;
    applyStimulus(1'b0, 100, 0, NPIX);
    checkOutput("midResetSof", sofCnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
